// File: rtl/random_delay_timer.sv
`default_nettype none
// ============================================================================
// Module   : random_delay_timer
// Purpose  : Reaction-time trial sequencer. On start it fetches a random
//            number, waits MIN_DELAY_MS + (random & RANGE_MASK) milliseconds,
//            then lights the stimulus and reports either a valid reaction
//            or a false start.
// Ports    : clk, reset           - clock, synchronous active-high reset
//            start, abort, press  - trial control and user button
//            randomNumber/Valid   - random source handshake (input side)
//            randomRequest        - random source handshake (request side)
//            delayActive          - high while in REQUEST or WAIT
//            stimulusOn           - stimulus LED, high in FIRE
//            falseStart, reacted  - one-cycle result pulses
//            capturedDelay[16:0]  - last captured delay (debug build only)
// Options  : define RANDOM_DELAY_DEBUG_EN to add the capturedDelay output.
// Revision : 1.0 - initial release
// ============================================================================
module random_delay_timer #(
  parameter int unsigned TICK_DIV     = 50000,
  parameter logic [15:0] MIN_DELAY_MS = 16'd1000,
  parameter logic [15:0] RANGE_MASK   = 16'h0FFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        abort,
  input  logic        press,
  input  logic [15:0] randomNumber,
  input  logic        randomValid,
  output logic        randomRequest,
  output logic        delayActive,
  output logic        stimulusOn,
  output logic        falseStart,
  output logic        reacted
`ifdef RANDOM_DELAY_DEBUG_EN
  ,
  output logic [16:0] capturedDelay
`endif
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_REQUEST = 2'd1;
  localparam logic [1:0] S_WAIT    = 2'd2;
  localparam logic [1:0] S_FIRE    = 2'd3;

  localparam int unsigned      PW          = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]    C_PRESC_MAX = PW'(TICK_DIV - 1);

  logic [1:0]    state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [16:0]   remaining_q, remaining_d;
  logic          false_start_q, false_start_d;
  logic          reacted_q, reacted_d;
  logic [16:0]   w_delay_ms;
  logic          w_tick;

  // 17-bit sum so the largest MIN + masked random cannot overflow.
  assign w_delay_ms = {1'b0, MIN_DELAY_MS} + {1'b0, randomNumber & RANGE_MASK};
  assign w_tick     = (presc_q == C_PRESC_MAX);

`ifdef RANDOM_DELAY_DEBUG_EN
  logic [16:0] delay_ms_q, delay_ms_d;
`endif

  always_comb begin
    state_d       = state_q;
    presc_d       = presc_q;
    remaining_d   = remaining_q;
    false_start_d = 1'b0;
    reacted_d     = 1'b0;
`ifdef RANDOM_DELAY_DEBUG_EN
    delay_ms_d    = delay_ms_q;
`endif
    if (abort) begin
      // Abort outranks press, so a simultaneous press produces no pulse.
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) state_d = S_REQUEST;
        end
        S_REQUEST: begin
          if (press) begin
            false_start_d = 1'b1;
            state_d       = S_IDLE;
          end else if (randomValid) begin
            remaining_d = w_delay_ms;
            presc_d     = '0;
            state_d     = S_WAIT;
`ifdef RANDOM_DELAY_DEBUG_EN
            delay_ms_d  = w_delay_ms;
`endif
          end
        end
        S_WAIT: begin
          // Press is checked before the tick: a press on the final tick
          // is still a false start.
          if (press) begin
            false_start_d = 1'b1;
            state_d       = S_IDLE;
          end else if (remaining_q == 17'd0) begin
            state_d = S_FIRE;
          end else if (w_tick) begin
            presc_d     = '0;
            remaining_d = remaining_q - 17'd1;
            if (remaining_q == 17'd1) state_d = S_FIRE;
          end else begin
            presc_d = presc_q + PW'(1);
          end
        end
        S_FIRE: begin
          if (press) begin
            reacted_d = 1'b1;
            state_d   = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      presc_q       <= '0;
      remaining_q   <= '0;
      false_start_q <= 1'b0;
      reacted_q     <= 1'b0;
`ifdef RANDOM_DELAY_DEBUG_EN
      delay_ms_q    <= '0;
`endif
    end else begin
      state_q       <= state_d;
      presc_q       <= presc_d;
      remaining_q   <= remaining_d;
      false_start_q <= false_start_d;
      reacted_q     <= reacted_d;
`ifdef RANDOM_DELAY_DEBUG_EN
      delay_ms_q    <= delay_ms_d;
`endif
    end
  end

  // Level outputs are pure state decodes; pulses come from flops.
  assign randomRequest = (state_q == S_REQUEST);
  assign delayActive   = (state_q == S_REQUEST) || (state_q == S_WAIT);
  assign stimulusOn    = (state_q == S_FIRE);
  assign falseStart    = false_start_q;
  assign reacted       = reacted_q;
`ifdef RANDOM_DELAY_DEBUG_EN
  assign capturedDelay = delay_ms_q;
`endif

endmodule
`default_nettype wire
